// File: rtl/load_vec_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_vec_if                                            |
// | Description : Signal bundle for the vector load unit. It carries the |
// |               command port, the DRAM read port and the               |
// |               vector-buffer write port.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface load_vec_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256
);
  localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;

  // Command port
  logic                  start;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic [9:0]            length;
  logic [4:0]            buf_id;
  logic                  busy;
  logic                  done;

  // DRAM read port: one outstanding request at a time
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  // Vector buffer write port: element i of the tile is buf_write_data[i]
  logic                                      buf_write_en;
  logic [4:0]                                buf_write_id;
  logic [0:TILE_ELEMS-1][DATA_WIDTH-1:0]     buf_write_data;
  logic                                      buf_write_done;

  // Environment side: issues commands, serves reads, accepts tiles
  modport master (
    output start, dram_addr, length, buf_id, mem_rdata, mem_valid, buf_write_done,
    input  busy, done, mem_req, mem_addr, buf_write_en, buf_write_id, buf_write_data
  );

  // Load unit side
  modport slave (
    input  start, dram_addr, length, buf_id, mem_rdata, mem_valid, buf_write_done,
    output busy, done, mem_req, mem_addr, buf_write_en, buf_write_id, buf_write_data
  );
endinterface
`default_nettype wire

// File: rtl/load_vec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_vec                                               |
// | Description : Vector load unit. Reads a run of bytes from DRAM, one  |
// |               outstanding read at a time, and packs them into tiles  |
// |               written to the vector buffer file. Unused tail         |
// |               elements of the last tile are zero.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_vec #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256
) (
  input  wire        clk,
  input  wire        rst_n,
  load_vec_if.slave  lv_io
);

  localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
  localparam int IDX_W      = $clog2(TILE_ELEMS);
  localparam int LEN_W      = 10;
  localparam int ID_W       = 5;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(TILE_ELEMS - 1);
  localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(TILE_ELEMS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Transfer context
  logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
  logic [IDX_W-1:0]      elem_idx_q,  elem_idx_d;
  logic [LEN_W-1:0]      loaded_q,    loaded_d;
  logic [LEN_W-1:0]      length_q,    length_d;
  logic [ID_W-1:0]       buf_id_q,    buf_id_d;

  // Tile under construction; it also feeds the buffer write data directly
  logic [0:TILE_ELEMS-1][DATA_WIDTH-1:0] tile_q, tile_d;

  // Registered outputs
  logic                  mem_req_q,  mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  buf_we_q,   buf_we_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  // Next-state logic; outputs are derived from the next state so that
  // they are registered yet line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    base_addr_d = base_addr_q;
    elem_idx_d  = elem_idx_q;
    loaded_d    = loaded_q;
    length_d    = length_q;
    buf_id_d    = buf_id_q;
    tile_d      = tile_q;

    case (state_q)
      S_IDLE: begin
        if (lv_io.start) begin
          base_addr_d = lv_io.dram_addr;
          buf_id_d    = lv_io.buf_id;
          length_d    = lv_io.length;
          elem_idx_d  = '0;
          loaded_d    = '0;
          tile_d      = '0;
          state_d     = (lv_io.length == '0) ? S_FINISH : S_REQ;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (lv_io.mem_valid) begin
          tile_d[elem_idx_q] = lv_io.mem_rdata;
          loaded_d           = loaded_q + LEN_W'(1);
          elem_idx_d         = elem_idx_q + IDX_W'(1);
          // Flush on a full tile or on the last requested element
          if ((elem_idx_q == LAST_IDX) || ((loaded_q + LEN_W'(1)) == length_q)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_WRITE: begin
        if (lv_io.buf_write_done) begin
          // Clearing here is what zero-pads a partial last tile
          tile_d = '0;
          if (loaded_q == length_q) begin
            state_d = S_FINISH;
          end else begin
            base_addr_d = base_addr_q + TILE_STEP;
            elem_idx_d  = '0;
            state_d     = S_REQ;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_req_d  = (state_d == S_REQ);
    mem_addr_d = mem_req_d ? (base_addr_d + ADDR_WIDTH'(elem_idx_d)) : mem_addr_q;
    buf_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  // State, context and output registers; reset discards any partial tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_addr_q <= '0;
      elem_idx_q  <= '0;
      loaded_q    <= '0;
      length_q    <= '0;
      buf_id_q    <= '0;
      tile_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      buf_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_addr_q <= base_addr_d;
      elem_idx_q  <= elem_idx_d;
      loaded_q    <= loaded_d;
      length_q    <= length_d;
      buf_id_q    <= buf_id_d;
      tile_q      <= tile_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      buf_we_q    <= buf_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lv_io.mem_req        = mem_req_q;
  assign lv_io.mem_addr       = mem_addr_q;
  assign lv_io.buf_write_en   = buf_we_q;
  assign lv_io.buf_write_id   = buf_id_q;
  assign lv_io.buf_write_data = tile_q;
  assign lv_io.busy           = busy_q;
  assign lv_io.done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_load_vec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_load_vec                                            |
// | Description : Directed self-checking bench for load_vec with a DRAM |
// |               model of programmable latency and a buffer model of   |
// |               programmable accept delay.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_load_vec;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int NE = 32;

  typedef logic [0:NE-1][DW-1:0] tile_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_vec_if lv_io ();

  load_vec u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lv_io (lv_io)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Environment knobs, written only by the stimulus block
  int lat_l    = 1;
  int lat_d    = 0;
  bit spurious = 1'b0;

  // Environment observations, written only by the environment block
  int            cyc        = 0;
  int            done_cnt   = 0;
  int            done_cyc   = 0;
  int            episodes   = 0;
  int            en_cycles  = 0;
  logic [AW-1:0] addr_q[$];
  tile_t         tile_cap[$];
  logic [4:0]    id_cap[$];

  // DRAM contents: a fixed function of the byte address
  function automatic logic [DW-1:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic tile_t exp_tile(input logic [AW-1:0] base, input int cnt);
    tile_t t;
    t = '0;
    for (int i = 0; i < cnt; i++) t[i] = mem_byte(base + AW'(i));
    return t;
  endfunction

  // DRAM model, buffer-file model and monitors, all on the falling edge
  bit            pend  = 1'b0;
  int            pcnt  = 0;
  logic [AW-1:0] paddr = '0;
  int            wcnt  = 0;
  logic          prev_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (lv_io.mem_req) addr_q.push_back(lv_io.mem_addr);
    if (lv_io.buf_write_en) begin
      en_cycles++;
      if (!prev_en) episodes++;
    end
    prev_en = lv_io.buf_write_en;
    if (lv_io.done) begin
      done_cnt++;
      done_cyc = cyc;
    end

    lv_io.mem_valid = 1'b0;
    lv_io.mem_rdata = '0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pcnt <= 1) begin
          lv_io.mem_valid = 1'b1;
          lv_io.mem_rdata = mem_byte(paddr);
          pend            = 1'b0;
        end else begin
          pcnt--;
        end
      end
      if (lv_io.mem_req) begin
        pend  = 1'b1;
        pcnt  = lat_l;
        paddr = lv_io.mem_addr;
      end
    end
    if (spurious) begin
      lv_io.mem_valid = 1'b1;
      lv_io.mem_rdata = 8'hEE;
    end

    lv_io.buf_write_done = 1'b0;
    if (rst_n && lv_io.buf_write_en) begin
      if (wcnt == lat_d) begin
        lv_io.buf_write_done = 1'b1;
        tile_cap.push_back(lv_io.buf_write_data);
        id_cap.push_back(lv_io.buf_write_id);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a command, optionally poke a second start mid-transfer, and
  // wait (bounded) for done. lat counts from the start cycle inclusive.
  task automatic run(input logic [AW-1:0] a, input logic [9:0] n, input logic [4:0] id,
                     input bit mid_start, output int lat);
    int base_done;
    int s_cyc;
    base_done       = done_cnt;
    lv_io.start     = 1'b1;
    lv_io.dram_addr = a;
    lv_io.length    = n;
    lv_io.buf_id    = id;
    s_cyc           = cyc;
    step();
    lv_io.start = 1'b0;
    check("busy_after_start", 256'(lv_io.busy), 256'(1));
    for (int k = 0; k < 5000 && done_cnt == base_done; k++) begin
      if (mid_start && k == 3) begin
        lv_io.start     = 1'b1;
        lv_io.dram_addr = 24'h000900;
        lv_io.length    = 10'd20;
        lv_io.buf_id    = 5'd30;
      end else begin
        lv_io.start = 1'b0;
      end
      step();
    end
    lv_io.start = 1'b0;
    check("done_seen", 256'(done_cnt - base_done), 256'(1));
    lat = done_cyc - s_cyc + 1;
    step();
    check("busy_after_done", 256'(lv_io.busy), 256'(0));
    check("done_one_cycle", 256'(lv_io.done), 256'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req"},  256'(lv_io.mem_req),      256'(0));
    check({tag, "_mem_addr"}, 256'(lv_io.mem_addr),     256'(0));
    check({tag, "_wr_en"},    256'(lv_io.buf_write_en), 256'(0));
    check({tag, "_wr_id"},    256'(lv_io.buf_write_id), 256'(0));
    check({tag, "_wr_data"},  lv_io.buf_write_data,     256'(0));
    check({tag, "_busy"},     256'(lv_io.busy),         256'(0));
    check({tag, "_done"},     256'(lv_io.done),         256'(0));
  endtask

  initial begin
    int lat;
    int ab, tb_i, ep0, en0;

    lv_io.start     = 1'b0;
    lv_io.dram_addr = '0;
    lv_io.length    = '0;
    lv_io.buf_id    = '0;

    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Short load: 5 bytes from 0x100, L=1, D=0
    lat_l = 1; lat_d = 0;
    ab = addr_q.size(); tb_i = tile_cap.size(); ep0 = episodes;
    run(24'h000100, 10'd5, 5'd3, 1'b0, lat);
    check("short_nreq", 256'(addr_q.size() - ab), 256'(5));
    for (int i = 0; i < 5; i++) check("short_addr", 256'(addr_q[ab + i]), 256'(24'h000100 + i));
    check("short_episodes", 256'(episodes - ep0), 256'(1));
    check("short_tile", tile_cap[tb_i], exp_tile(24'h000100, 5));
    check("short_id", 256'(id_cap[tb_i]), 256'(3));
    check("short_latency", 256'(lat), 256'(13));

    // Exact tile: 32 bytes, single write, no extra request
    ab = addr_q.size(); tb_i = tile_cap.size(); ep0 = episodes;
    run(24'h002000, 10'd32, 5'd7, 1'b0, lat);
    check("exact_nreq", 256'(addr_q.size() - ab), 256'(32));
    check("exact_last_addr", 256'(addr_q[ab + 31]), 256'(24'h00201F));
    check("exact_episodes", 256'(episodes - ep0), 256'(1));
    check("exact_tile", tile_cap[tb_i], exp_tile(24'h002000, 32));
    check("exact_latency", 256'(lat), 256'(67));

    // Two tiles with address wrap and 24 zero pad elements
    ab = addr_q.size(); tb_i = tile_cap.size(); ep0 = episodes;
    run(24'hFFFFF0, 10'd40, 5'd12, 1'b0, lat);
    check("two_nreq", 256'(addr_q.size() - ab), 256'(40));
    check("two_wrap_addr", 256'(addr_q[ab + 16]), 256'(24'h000000));
    check("two_second_base", 256'(addr_q[ab + 32]), 256'(24'h000010));
    check("two_episodes", 256'(episodes - ep0), 256'(2));
    check("two_tile0", tile_cap[tb_i], exp_tile(24'hFFFFF0, 32));
    check("two_tile1", tile_cap[tb_i + 1], exp_tile(24'h000010, 8));
    check("two_latency", 256'(lat), 256'(84));

    // Slow memory, slow buffer, stray mem_valid while idle
    lat_l = 3; lat_d = 4;
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    step();
    check("spur_busy", 256'(lv_io.busy), 256'(0));
    check("spur_data", lv_io.buf_write_data, 256'(0));
    ab = addr_q.size(); tb_i = tile_cap.size(); en0 = en_cycles;
    run(24'h000500, 10'd6, 5'd9, 1'b0, lat);
    check("slow_nreq", 256'(addr_q.size() - ab), 256'(6));
    check("slow_en_cycles", 256'(en_cycles - en0), 256'(5));
    check("slow_tile", tile_cap[tb_i], exp_tile(24'h000500, 6));
    check("slow_latency", 256'(lat), 256'(31));

    // Zero length: done after 2 cycles, no traffic
    lat_l = 1; lat_d = 0;
    ab = addr_q.size(); ep0 = episodes;
    run(24'h000A00, 10'd0, 5'd1, 1'b0, lat);
    check("zero_latency", 256'(lat), 256'(2));
    check("zero_nreq", 256'(addr_q.size() - ab), 256'(0));
    check("zero_episodes", 256'(episodes - ep0), 256'(0));

    // Start while busy is ignored
    ab = addr_q.size(); tb_i = tile_cap.size();
    run(24'h000300, 10'd5, 5'd4, 1'b1, lat);
    check("busy_start_nreq", 256'(addr_q.size() - ab), 256'(5));
    check("busy_start_addr4", 256'(addr_q[ab + 4]), 256'(24'h000304));
    check("busy_start_tile", tile_cap[tb_i], exp_tile(24'h000300, 5));
    check("busy_start_id", 256'(id_cap[tb_i]), 256'(4));
    check("busy_start_latency", 256'(lat), 256'(13));

    // Reset during WAIT of element 3
    lat_l = 3;
    ab = addr_q.size();
    lv_io.start     = 1'b1;
    lv_io.dram_addr = 24'h000700;
    lv_io.length    = 10'd10;
    lv_io.buf_id    = 5'd21;
    step();
    lv_io.start = 1'b0;
    for (int k = 0; k < 200 && (addr_q.size() - ab) < 4; k++) step();
    check("rst_reached_elem3", 256'(addr_q.size() - ab), 256'(4));
    step();
    check("rst_pre_busy", 256'(lv_io.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    step();
    step();
    rst_n = 1'b1;
    step();
    lat_l = 1;
    ab = addr_q.size(); tb_i = tile_cap.size();
    run(24'h000800, 10'd3, 5'd2, 1'b0, lat);
    check("post_rst_first_addr", 256'(addr_q[ab]), 256'(24'h000800));
    check("post_rst_nreq", 256'(addr_q.size() - ab), 256'(3));
    check("post_rst_tile", tile_cap[tb_i], exp_tile(24'h000800, 3));
    check("post_rst_latency", 256'(lat), 256'(9));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
